register_addr_bank: RTL
=======================

Name: register_addr_bank

Overview:
- Parametrised bank of COUNT 16-bit address registers, replacing the individually instantiated pcra0/pcra1/sp/si/di register_addr instances.
- Each register can:
  - drive the addr bus or the xfer bus via index selects;
  - load from the xfer bus;
  - increment or decrement independently;
  - be loaded bytewise from the 8-bit main bus through a two-step low/high staging sequence.
- Drive outputs feed the shared bus muxes as one out/en pair per bus. Optional sticky error reporting flags misuse.

Parameters:
- WIDTH_AX, 16: addr/xfer bus and register width in bits.
- WIDTH_MAIN, 8: main bus width; WIDTH_AX must equal 2*WIDTH_MAIN.
- COUNT, 5: number of registers, index 0..COUNT-1.
- SEL_W, 3: select index width; 2**SEL_W >= COUNT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr_assert  in  1  drive register addr_sel onto the addr bus.
- addr_sel  in  SEL_W  register index for the addr bus.
- xfer_assert  in  1  drive register xfer_sel onto the xfer bus.
- xfer_sel  in  SEL_W  register index for the xfer bus.
- load_xfer  in  1  load register load_sel from xfer_in.
- load_sel  in  SEL_W  target index for load_xfer and load_high_main.
- xfer_in  in  WIDTH_AX  resolved xfer bus value.
- main_in  in  WIDTH_MAIN  resolved main bus value.
- load_low_main  in  1  capture main_in into the low-byte stage.
- load_high_main  in  1  commit {main_in, stage} to register load_sel.
- inc  in  COUNT  per-register increment.
- dec  in  COUNT  per-register decrement.
- addr_out  out  WIDTH_AX  addr bus drive value.
- addr_en  out  1  addr bus drive enable.
- xfer_out  out  WIDTH_AX  xfer bus drive value.
- xfer_en  out  1  xfer bus drive enable.
- stage_valid  out  1  low byte staged, waiting for commit.
- err  out  1  sticky error flag; exists only with ADDR_BANK_ERR_EN.

Behaviour:

Reset
- Async reset forces all registers to 0, stage to 0, FSM to IDLE, err to 0.
- Reset applies mid-sequence: a staged low byte is discarded.

Bus drive (combinational, zero latency)
- addr_en = addr_assert && (addr_sel < COUNT).
- addr_out = reg[addr_sel] when addr_en, else 0.
- xfer_en and xfer_out are identical, using xfer_sel.
- Out-of-range select: enable stays 0 and output is 0.

Register update (rising edge), priority per register i:
1. Full load: load_xfer && load_sel==i loads xfer_in.
2. Commit: FSM in LOW_HELD && load_high_main && load_sel==i loads {main_in, stage}.
3. Count: inc[i] ^ dec[i]; inc adds 1, dec subtracts 1, modulo 2**WIDTH_AX.
   - Wrap: 0xFFFF+1 = 0x0000; 0x0000-1 = 0xFFFF.
   - inc[i] && dec[i] together: register holds its value.
- A lower-priority operation on the same register in the same cycle is dropped.
- Several registers may count in the same cycle.
- Self-transfer is legal: xfer_assert and load_xfer on the same index reloads the unchanged value.

Byte-load FSM, states IDLE and LOW_HELD
- IDLE:
  - load_low_main: stage <= main_in, go to LOW_HELD.
  - load_high_main: ignored, no write (error event).
- LOW_HELD:
  - load_low_main alone: stage overwritten, stay in LOW_HELD.
  - load_high_main alone: commit, stage <= 0, go to IDLE.
  - Both asserted: commit uses the old stage; the new main_in is then re-staged and the FSM stays in LOW_HELD.
- Commit with load_sel >= COUNT: no write, FSM still returns to IDLE (error event).
- Commit also loses to load_xfer on the same index (error event).
- stage_valid = (state == LOW_HELD).

Error events (used by the optional feature)
- load_xfer with load_sel >= COUNT.
- Orphan load_high_main in IDLE.
- Invalid commit index.
- Commit/load_xfer collision on the same index.
- inc[i] && dec[i].

Optional Feature:
- ADDR_BANK_ERR_EN defined:
  - err is set on the clock edge after any error event.
  - err stays set until reset.
- ADDR_BANK_ERR_EN undefined:
  - err port and its logic are absent.
  - All datapath behaviour is unchanged.

Test Plan:
1. Reset, then load_xfer=1, load_sel=3, xfer_in=0x1234; next cycle addr_assert=1, addr_sel=3.
   -> addr_en=1, addr_out=0x1234; xfer_en=0.
2. reg1=0xFFFF and reg2=0x0000; pulse inc[1] and dec[2] in the same cycle.
   -> reg1=0x0000, reg2=0xFFFF. Then inc[0]=dec[0]=1 for one cycle -> reg0 unchanged, err=1 (ERR_EN).
3. load_low_main with main_in=0xCD; next cycle load_high_main with main_in=0xAB, load_sel=4.
   -> reg4=0xABCD; stage_valid goes 1 then 0.
4. load_high_main in IDLE with load_sel=0.
   -> reg0 unchanged, err=1.
   Separately, same-cycle load_xfer(0x5555) and commit, both to index 2 -> reg2=0x5555, err=1.
5. Stage low byte 0x11, assert reset for one cycle, then load_high_main with main_in=0x22.
   -> no write, stage_valid=0, err=1 (reset cleared the stage).
6. addr_sel=6 with COUNT=5 and addr_assert=1.
   -> addr_en=0, addr_out=0.
   Load from xfer with load_sel=7 -> no register changes, err=1.

Source files
------------

// File: rtl/register_addr_bank_if.sv
// Bus-side signal bundle for register_addr_bank: drive selects, load controls,
// count strobes and the addr/xfer drive pairs that feed the shared bus muxes.
interface register_addr_bank_if #(
    parameter int WIDTH_AX   = 16,
    parameter int WIDTH_MAIN = 8,
    parameter int COUNT      = 5,
    parameter int SEL_W      = 3
);
    logic                  addr_assert;
    logic [SEL_W-1:0]      addr_sel;
    logic                  xfer_assert;
    logic [SEL_W-1:0]      xfer_sel;
    logic                  load_xfer;
    logic [SEL_W-1:0]      load_sel;
    logic [WIDTH_AX-1:0]   xfer_in;
    logic [WIDTH_MAIN-1:0] main_in;
    logic                  load_low_main;
    logic                  load_high_main;
    logic [COUNT-1:0]      inc;
    logic [COUNT-1:0]      dec;
    logic [WIDTH_AX-1:0]   addr_out;
    logic                  addr_en;
    logic [WIDTH_AX-1:0]   xfer_out;
    logic                  xfer_en;
    logic                  stage_valid;

    modport master (
        output addr_assert, addr_sel, xfer_assert, xfer_sel, load_xfer, load_sel,
               xfer_in, main_in, load_low_main, load_high_main, inc, dec,
        input  addr_out, addr_en, xfer_out, xfer_en, stage_valid
    );

    modport slave (
        input  addr_assert, addr_sel, xfer_assert, xfer_sel, load_xfer, load_sel,
               xfer_in, main_in, load_low_main, load_high_main, inc, dec,
        output addr_out, addr_en, xfer_out, xfer_en, stage_valid
    );
endinterface

// File: rtl/register_addr_bank.sv
// Bank of COUNT address registers with addr/xfer drive, xfer load, inc/dec and a
// two-step main-bus byte load. Define ADDR_BANK_ERR_EN to add the sticky err output.
module register_addr_bank #(
    parameter int WIDTH_AX   = 16,
    parameter int WIDTH_MAIN = 8,
    parameter int COUNT      = 5,
    parameter int SEL_W      = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    register_addr_bank_if.slave  bus
`ifdef ADDR_BANK_ERR_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic {IDLE, LOW_HELD} state_t;

    state_t                state;
    logic [WIDTH_MAIN-1:0] stage;
    logic [WIDTH_AX-1:0]   regs [COUNT];
    logic                  commit_fire;

    assign commit_fire     = (state == LOW_HELD) && bus.load_high_main;
    assign bus.stage_valid = (state == LOW_HELD);

    // Out-of-range selects match no loop index, so enable and data stay zero.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        bus.addr_en  = 1'b0;
        bus.addr_out = '0;
        bus.xfer_en  = 1'b0;
        bus.xfer_out = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (bus.addr_assert && bus.addr_sel == i[SEL_W-1:0]) begin
                bus.addr_en  = 1'b1;
                bus.addr_out = regs[i];
            end
            if (bus.xfer_assert && bus.xfer_sel == i[SEL_W-1:0]) begin
                bus.xfer_en  = 1'b1;
                bus.xfer_out = regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            stage <= '0;
            // NOTE: these are flops rather than a RAM, so clearing every entry on reset is intended.
            for (int i = 0; i < COUNT; i++) regs[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            for (int i = 0; i < COUNT; i++) begin
                if (bus.load_xfer && bus.load_sel == i[SEL_W-1:0])
                    regs[i] <= bus.xfer_in;
                else if (commit_fire && bus.load_sel == i[SEL_W-1:0])
                    regs[i] <= {bus.main_in, stage};
                else if (bus.inc[i] && !bus.dec[i])
                    regs[i] <= regs[i] + WIDTH_AX'(1);
                else if (bus.dec[i] && !bus.inc[i])
                    regs[i] <= regs[i] - WIDTH_AX'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.load_low_main) begin
                        stage <= bus.main_in;
                        state <= LOW_HELD;
                    end
                end
                LOW_HELD: begin
                    // The commit above used the old stage; a simultaneous low load re-stages.
                    if (bus.load_low_main) begin
                        stage <= bus.main_in;
                    end else if (bus.load_high_main) begin
                        stage <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDR_BANK_ERR_EN
    function automatic logic sel_ok(input logic [SEL_W-1:0] sel);
        return {1'b0, sel} < COUNT[SEL_W:0];
    endfunction

    logic err_event;

    // load_xfer and commit share load_sel, so any overlap is a same-index collision.
    always_comb begin
        err_event = 1'b0;
        if (bus.load_xfer && !sel_ok(bus.load_sel))  err_event = 1'b1;
        if (state == IDLE && bus.load_high_main)     err_event = 1'b1;
        if (commit_fire && !sel_ok(bus.load_sel))    err_event = 1'b1;
        if (commit_fire && bus.load_xfer)            err_event = 1'b1;
        if (|(bus.inc & bus.dec))                    err_event = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          err <= 1'b0;
        else if (err_event) err <= 1'b1;
    end
`endif

endmodule
